// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters with registered syncs, blank and frame/line markers.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  logic [9:0] hc, vc, hc_n, vc_n;
  logic       fs_n;
  assign DrawX = hc;
  assign DrawY = vc;
  // Decode the next-state counters so every flag lands in the same cycle as its count.
  always_comb begin
    hc_n = (hc == H_LAST) ? 10'd0 : hc + 10'd1;
    vc_n = (hc != H_LAST) ? vc : (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    fs_n = (hc_n == 10'd0) && (vc_n == 10'd0);
  end
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      hc          <= hc_n;
      vc          <= vc_n;
      hs          <= !((hc_n >= HS_BEG) && (hc_n <= HS_END));
      vs          <= !((vc_n >= VS_BEG) && (vc_n <= VS_END));
      blank       <= (hc_n < H_VIS) && (vc_n < V_VIS);
      line_start  <= (hc_n == 10'd0);
      frame_start <= fs_n;
      frame_count <= frame_count + 8'(fs_n);
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of full-size line timing and a shrunken raster for frame-level behaviour.
module tb_vga_timing_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_rst_n = 1'b0;
  logic [9:0] draw_x, draw_y, s_draw_x, s_draw_y;
  logic       hs, vs, blank, line_start, frame_start;
  logic       s_hs, s_vs, s_blank, s_line_start, s_frame_start;
  logic [7:0] frame_count, s_frame_count;
  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y), .hs(hs), .vs(vs),
    .blank(blank), .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_s (
    .vga_clk(clk), .reset_n(s_rst_n), .DrawX(s_draw_x), .DrawY(s_draw_y), .hs(s_hs), .vs(s_vs),
    .blank(s_blank), .line_start(s_line_start), .frame_start(s_frame_start), .frame_count(s_frame_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    step(3);
    chk("rst_x", 32'(draw_x), 799);
    chk("rst_y", 32'(draw_y), 524);
    chk("rst_hs", 32'(hs), 1);
    chk("rst_vs", 32'(vs), 1);
    chk("rst_blank", 32'(blank), 0);
    chk("rst_ls", 32'(line_start), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_fc", 32'(frame_count), 0);
    rst_n = 1'b1;
    step(1);
    chk("rel_x", 32'(draw_x), 0);
    chk("rel_y", 32'(draw_y), 0);
    chk("rel_blank", 32'(blank), 1);
    chk("rel_ls", 32'(line_start), 1);
    chk("rel_fs", 32'(frame_start), 1);
    chk("rel_fc", 32'(frame_count), 1);
    for (int x = 0; x < 800; x++) begin
      chk("l0_x", 32'(draw_x), 32'(x));
      chk("l0_y", 32'(draw_y), 0);
      chk("l0_blank", 32'(blank), 32'(x < 640));
      chk("l0_hs", 32'(hs), 32'(!(x >= 656 && x <= 751)));
      chk("l0_vs", 32'(vs), 1);
      chk("l0_ls", 32'(line_start), 32'(x == 0));
      step(1);
    end
    chk("wrap_x", 32'(draw_x), 0);
    chk("wrap_y", 32'(draw_y), 1);
    chk("wrap_ls", 32'(line_start), 1);
    chk("wrap_fs", 32'(frame_start), 0);
    step(1);
    chk("wrap_ls_off", 32'(line_start), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async_x", 32'(draw_x), 799);
    chk("async_y", 32'(draw_y), 524);
    chk("async_blank", 32'(blank), 0);
    chk("async_fc", 32'(frame_count), 0);
    step(2);
    s_rst_n = 1'b1;
    step(1);
    chk("s_rel_fs", 32'(s_frame_start), 1);
    chk("s_rel_fc", 32'(s_frame_count), 1);
    for (int i = 0; i < 98; i++) begin
      chk("s_x", 32'(s_draw_x), 32'(i % 14));
      chk("s_y", 32'(s_draw_y), 32'(i / 14));
      chk("s_hs", 32'(s_hs), 32'(!((i % 14) >= 10 && (i % 14) <= 11)));
      chk("s_vs", 32'(s_vs), 32'((i / 14) != 5));
      chk("s_blank", 32'(s_blank), 32'((i % 14) < 8 && (i / 14) < 4));
      chk("s_ls", 32'(s_line_start), 32'((i % 14) == 0));
      chk("s_fs", 32'(s_frame_start), 32'(i == 0));
      step(1);
    end
    chk("s_f2_fs", 32'(s_frame_start), 1);
    chk("s_f2_fc", 32'(s_frame_count), 2);
    chk("s_f2_xy", 32'({s_draw_x, s_draw_y}), 0);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!s_frame_start && n < 200);
    chk("s_period", 32'(n), 98);
    chk("s_f3_fc", 32'(s_frame_count), 3);
    step(252 * 98);
    chk("s_fc255", 32'(s_frame_count), 255);
    chk("s_fc255_fs", 32'(s_frame_start), 1);
    step(98);
    chk("s_fc0", 32'(s_frame_count), 0);
    chk("s_fc0_fs", 32'(s_frame_start), 1);
    step(98);
    chk("s_fc1", 32'(s_frame_count), 1);
    step(5 * 14 + 11);
    chk("s_mid_x", 32'(s_draw_x), 11);
    chk("s_mid_y", 32'(s_draw_y), 5);
    chk("s_mid_hs", 32'(s_hs), 0);
    chk("s_mid_vs", 32'(s_vs), 0);
    #3 s_rst_n = 1'b0;
    #1;
    chk("s_ar_x", 32'(s_draw_x), 13);
    chk("s_ar_y", 32'(s_draw_y), 6);
    chk("s_ar_hs", 32'(s_hs), 1);
    chk("s_ar_vs", 32'(s_vs), 1);
    chk("s_ar_blank", 32'(s_blank), 0);
    chk("s_ar_fc", 32'(s_frame_count), 0);
    step(1);
    chk("s_hold_x", 32'(s_draw_x), 13);
    chk("s_hold_fs", 32'(s_frame_start), 0);
    s_rst_n = 1'b1;
    step(1);
    chk("s_rs_xy", 32'({s_draw_x, s_draw_y}), 0);
    chk("s_rs_fs", 32'(s_frame_start), 1);
    chk("s_rs_fc", 32'(s_frame_count), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
